sq_sig_filter_mc: RTL and testbench

Multi-channel, parametrised deglitch filter for noisy square-wave inputs, feeding the frequency/period counters. Each channel synchronises its raw input, then applies one of three run-time-selectable filters: bypass, asymmetric consecutive-run, or saturating integrator. Per channel it outputs the filtered level, single-cycle rise/fall strobes for edge-triggered counters, and a saturating count of rejected glitches.

---
 rtl/sq_sig_filter_mc.sv | 138 +++++++++++++
 tb/tb_sq_sig_filter_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sq_sig_filter_mc.sv
// Multi-channel deglitch filter for noisy square-wave inputs: per-channel
// 2-flop sync, then bypass / asymmetric consecutive-run / saturating integrator.
module sq_sig_filter_mc #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned GC_W  = 16
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    input  logic [CH-1:0]        sq_sig,
    input  logic [CNT_W-1:0]     win_len_h,
    input  logic [CNT_W-1:0]     win_len_l,
    input  logic [1:0]           mode,
    input  logic                 glitch_clr,
    output logic [CH-1:0]        sq_sig_filter,
    output logic [CH-1:0]        rise_pls,
    output logic [CH-1:0]        fall_pls,
    output logic [CH*GC_W-1:0]   glitch_cnt
);

    localparam int unsigned CW1 = CNT_W + 1;

    localparam logic [1:0] MODE_CONS = 2'd1;
    localparam logic [1:0] MODE_INTG = 2'd2;

    localparam logic [GC_W-1:0] GC_MAX = '1;

    logic [CH-1:0]    s1_q;
    logic [CH-1:0]    s2_q;
    logic [1:0]       mode_q;
    logic [CH-1:0]    filt_d;
    logic [CH-1:0]    rise_d;
    logic [CH-1:0]    fall_d;
    logic [CH-1:0]    glitch_c;
    logic [CNT_W-1:0] cnt_q   [CH];
    logic [CNT_W-1:0] cnt_d   [CH];
    logic [CW1-1:0]   cnt_inc [CH];
    logic [GC_W-1:0]  gc_q    [CH];
    logic [GC_W-1:0]  gc_d    [CH];
    logic [CNT_W-1:0] weff_h;
    logic [CNT_W-1:0] weff_l;
    logic             mode_chg_c;

    // A zero window behaves as a one-sample window.
    assign weff_h     = (win_len_h == '0) ? CNT_W'(1) : win_len_h;
    assign weff_l     = (win_len_l == '0) ? CNT_W'(1) : win_len_l;
    assign mode_chg_c = (mode != mode_q);

    // Input synchroniser and mode tracking.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            mode_q <= 2'd0;
        end else begin
            s1_q   <= sq_sig;
            s2_q   <= s1_q;
            mode_q <= mode;
        end
    end

    // Per-channel filter next-state.
    always_comb begin
        filt_d   = sq_sig_filter;
        glitch_c = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i]   = '0;
            gc_d[i]    = gc_q[i];
            cnt_inc[i] = {1'b0, cnt_q[i]} + CW1'(1);

            // A mode change only clears the run state; the output holds.
            if (!mode_chg_c) begin
                case (mode)
                    MODE_CONS: begin
                        if (s2_q[i] == sq_sig_filter[i]) begin
                            glitch_c[i] = (cnt_q[i] != '0);
                        end else if (cnt_inc[i] >= {1'b0, (sq_sig_filter[i] ? weff_l : weff_h)}) begin
                            filt_d[i] = ~sq_sig_filter[i];
                        end else begin
                            cnt_d[i] = cnt_inc[i][CNT_W-1:0];
                        end
                    end
                    MODE_INTG: begin
                        if (s2_q[i]) begin
                            cnt_d[i] = (cnt_inc[i] >= {1'b0, weff_h}) ? weff_h
                                                                      : cnt_inc[i][CNT_W-1:0];
                        end else begin
                            cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CNT_W'(1);
                        end
                        if (cnt_d[i] == weff_h) begin
                            filt_d[i] = 1'b1;
                        end else if (cnt_d[i] == '0) begin
                            filt_d[i] = 1'b0;
                        end
                    end
                    default: begin
                        filt_d[i] = s2_q[i];
                    end
                endcase
            end

            // Clear takes priority over a coincident glitch.
            if (glitch_clr) begin
                gc_d[i] = '0;
            end else if (glitch_c[i] && (gc_q[i] != GC_MAX)) begin
                gc_d[i] = gc_q[i] + GC_W'(1);
            end
        end
        rise_d = filt_d & ~sq_sig_filter;
        fall_d = ~filt_d & sq_sig_filter;
    end

    // Filter state, strobes and counters.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sq_sig_filter <= '0;
            rise_pls      <= '0;
            fall_pls      <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
                gc_q[i]  <= '0;
            end
        end else begin
            sq_sig_filter <= filt_d;
            rise_pls      <= rise_d;
            fall_pls      <= fall_d;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                gc_q[i]  <= gc_d[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_gc_pack
        assign glitch_cnt[g*GC_W +: GC_W] = gc_q[g];
    end

endmodule

// File: tb/tb_sq_sig_filter_mc.sv
// Directed self-checking bench for sq_sig_filter_mc; expected values are
// hand-derived from the filter latencies (edge 2+weff consecutive, 2+W integrator).
module tb_sq_sig_filter_mc;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned GC_W  = 8;

    logic               clk_100M;
    logic               rst_n;
    logic [CH-1:0]      sq_sig;
    logic [CNT_W-1:0]   win_len_h;
    logic [CNT_W-1:0]   win_len_l;
    logic [1:0]         mode;
    logic               glitch_clr;
    logic [CH-1:0]      sq_sig_filter;
    logic [CH-1:0]      rise_pls;
    logic [CH-1:0]      fall_pls;
    logic [CH*GC_W-1:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    sq_sig_filter_mc #(.CH(CH), .CNT_W(CNT_W), .GC_W(GC_W)) dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .sq_sig        (sq_sig),
        .win_len_h     (win_len_h),
        .win_len_l     (win_len_l),
        .mode          (mode),
        .glitch_clr    (glitch_clr),
        .sq_sig_filter (sq_sig_filter),
        .rise_pls      (rise_pls),
        .fall_pls      (fall_pls),
        .glitch_cnt    (glitch_cnt)
    );

    initial begin
        clk_100M = 1'b0;
        forever #5 clk_100M = ~clk_100M;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sq_sig     = '0;
        win_len_h  = 32'd1;
        win_len_l  = 32'd1;
        mode       = 2'd0;
        glitch_clr = 1'b0;

        // Reset state
        edges(3);
        chk("rst_filter", 64'(sq_sig_filter), 64'h0);
        chk("rst_rise",   64'(rise_pls),      64'h0);
        chk("rst_fall",   64'(fall_pls),      64'h0);
        chk("rst_gc",     64'(glitch_cnt),    64'h0);
        rst_n = 1'b1;
        edges(4);

        // Bypass: output follows the pin three edges later
        sq_sig = 4'b0001;
        edges(2);
        chk("byp_e2_filter", 64'(sq_sig_filter), 64'h0);
        edges(1);
        chk("byp_e3_filter", 64'(sq_sig_filter), 64'h1);
        chk("byp_e3_rise",   64'(rise_pls),      64'h1);
        chk("byp_e3_fall",   64'(fall_pls),      64'h0);
        edges(1);
        chk("byp_e4_rise",   64'(rise_pls),      64'h0);
        sq_sig = 4'b0000;
        edges(3);
        chk("byp_fall_filter", 64'(sq_sig_filter), 64'h0);
        chk("byp_fall_pls",    64'(fall_pls),      64'h1);

        // Consecutive, asymmetric windows 5 / 10
        mode      = 2'd1;
        win_len_h = 32'd5;
        win_len_l = 32'd10;
        edges(3);
        sq_sig = 4'b0001;
        edges(6);
        chk("cons_e6_filter", 64'(sq_sig_filter), 64'h0);
        edges(1);
        chk("cons_e7_filter", 64'(sq_sig_filter), 64'h1);
        chk("cons_e7_rise",   64'(rise_pls),      64'h1);
        sq_sig = 4'b0000;
        edges(11);
        chk("cons_e11_filter", 64'(sq_sig_filter), 64'h1);
        edges(1);
        chk("cons_e12_filter", 64'(sq_sig_filter), 64'h0);
        chk("cons_e12_fall",   64'(fall_pls),      64'h1);
        chk("cons_gc",         64'(glitch_cnt),    64'h0);

        // Glitch rejection on channel 2 with window 8
        win_len_h = 32'd8;
        edges(2);
        for (int k = 0; k < 3; k++) begin
            sq_sig[2] = 1'b1;
            edges(3);
            sq_sig[2] = 1'b0;
            edges(3);
        end
        edges(3);
        chk("glitch_filter", 64'(sq_sig_filter), 64'h0);
        chk("glitch_cnt3",   64'(glitch_cnt),    64'h0003_0000);
        glitch_clr = 1'b1;
        edges(1);
        glitch_clr = 1'b0;
        chk("glitch_clr", 64'(glitch_cnt), 64'h0);

        // Integrator W=4 on channel 1, samples 1,1,0,1,1,1 then 0,0,0,0
        mode      = 2'd2;
        win_len_h = 32'd4;
        edges(3);
        begin
            logic [5:0] pat;
            pat = 6'b111011;
            for (int i = 0; i < 6; i++) begin
                sq_sig[1] = pat[i];
                edges(1);
            end
        end
        edges(1);
        chk("intg_pre_rise", 64'(sq_sig_filter), 64'h0);
        edges(1);
        chk("intg_rise_filter", 64'(sq_sig_filter), 64'h2);
        chk("intg_rise_pls",    64'(rise_pls),      64'h2);
        sq_sig[1] = 1'b0;
        edges(5);
        chk("intg_pre_fall", 64'(sq_sig_filter), 64'h2);
        edges(1);
        chk("intg_fall_filter", 64'(sq_sig_filter), 64'h0);
        chk("intg_fall_pls",    64'(fall_pls),      64'h2);
        chk("intg_gc",          64'(glitch_cnt),    64'h0);

        // Zero window behaves as one on channel 3
        mode      = 2'd1;
        win_len_h = 32'd0;
        edges(3);
        sq_sig[3] = 1'b1;
        edges(2);
        chk("zwin_e2_filter", 64'(sq_sig_filter), 64'h0);
        edges(1);
        chk("zwin_e3_filter", 64'(sq_sig_filter), 64'h8);
        chk("zwin_e3_rise",   64'(rise_pls),      64'h8);

        // Glitch counter saturation: 2^GC_W+5 one-sample glitches on channel 0
        win_len_h = 32'd3;
        for (int i = 0; i < (1 << GC_W) + 5; i++) begin
            sq_sig[0] = 1'b1;
            edges(1);
            sq_sig[0] = 1'b0;
            edges(1);
        end
        edges(4);
        chk("sat_gc",     64'(glitch_cnt),    64'h0000_00FF);
        chk("sat_filter", 64'(sq_sig_filter), 64'h8);

        // Window lowered mid-run at cnt=6 on channel 1
        win_len_h = 32'd10;
        sq_sig[1] = 1'b1;
        edges(8);
        chk("midwin_e8_filter", 64'(sq_sig_filter), 64'h8);
        win_len_h = 32'd4;
        edges(1);
        chk("midwin_e9_filter", 64'(sq_sig_filter), 64'hA);
        chk("midwin_e9_rise",   64'(rise_pls),      64'h2);

        // Mode switch to integrator mid-run clears cnt on channel 0
        win_len_h = 32'd10;
        sq_sig[0] = 1'b1;
        edges(5);
        mode      = 2'd2;
        win_len_h = 32'd4;
        edges(4);
        chk("modesw_e9_filter", 64'(sq_sig_filter), 64'hA);
        edges(1);
        chk("modesw_e10_filter", 64'(sq_sig_filter), 64'hB);
        chk("modesw_e10_rise",   64'(rise_pls),      64'h1);
        chk("modesw_gc",         64'(glitch_cnt),    64'h0000_00FF);

        // Asynchronous reset mid-run
        edges(2);
        rst_n = 1'b0;
        #2;
        chk("arst_filter", 64'(sq_sig_filter), 64'h0);
        chk("arst_rise",   64'(rise_pls),      64'h0);
        chk("arst_fall",   64'(fall_pls),      64'h0);
        chk("arst_gc",     64'(glitch_cnt),    64'h0);
        edges(2);
        rst_n = 1'b1;
        edges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
